nand_chain_exerciser: RTL

- Sequential stimulus/checker stage wrapped around the cascaded two-stage NAND block (d = ~(a&b), e = ~(c&d)).
- Upstream role: drives a/b/c through all 8 input combinations on a start command.
- Downstream role: samples the returned d/e after a programmable settle time and compares them to the golden truth table.
- Reports a per-pattern fail mask, a saturating error count and a pass/done summary. Used on the lab board and in simulation benches for the gate exercises.

---
 rtl/nand_chain_exerciser_if.sv | 28 ++
 rtl/nand_chain_exerciser.sv | 115 +++++++++++
 2 files changed

// File: rtl/nand_chain_exerciser_if.sv
// Signal bundle between the NAND-chain exerciser and the board/bench side.
// The master modport belongs to the exerciser. The slave modport belongs to whoever supplies start and d/e.
interface nand_chain_exerciser_if #(
  parameter int ERR_W = 4
) ();
  logic             start;
  logic             a_out;
  logic             b_out;
  logic             c_out;
  logic             d_in;
  logic             e_in;
  logic [2:0]       pattern;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [7:0]       fail_vec;

  modport master (
    input  start, d_in, e_in,
    output a_out, b_out, c_out, pattern, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    output start, d_in, e_in,
    input  a_out, b_out, c_out, pattern, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/nand_chain_exerciser.sv
// Sweeps a/b/c through all 8 patterns and waits a programmable settle time for each one.
// It then checks the returned d/e against the cascaded-NAND truth table and records failures.
module nand_chain_exerciser #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  nand_chain_exerciser_if.master  bus,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

  localparam logic [7:0]       RELOAD  = 8'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t           state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [2:0]       pattern_q, pattern_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic             pass_q, pass_nxt;
  logic [ERR_W-1:0] err_q, err_nxt;
  logic [7:0]       fail_q, fail_nxt;
  logic             exp_d, exp_e, mismatch;

  // Stimulus bits come straight from the pattern flops, so they are registered outputs too
  assign bus.a_out     = pattern_q[2];
  assign bus.b_out     = pattern_q[1];
  assign bus.c_out     = pattern_q[0];
  assign bus.pattern   = pattern_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fail_q;
  assign state_dbg     = state;

  assign exp_d    = ~(pattern_q[2] & pattern_q[1]);
  assign exp_e    = ~(pattern_q[0] & exp_d);
  assign mismatch = (bus.d_in != exp_d) || (bus.e_in != exp_e);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pattern_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      fail_q    <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pattern_q <= pattern_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      pass_q    <= pass_nxt;
      err_q     <= err_nxt;
      fail_q    <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pattern_nxt = pattern_q;
    busy_nxt    = busy_q;
    done_nxt    = 1'b0;
    pass_nxt    = pass_q;
    err_nxt     = err_q;
    fail_nxt    = fail_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt   = WAIT;
          pattern_nxt = 3'd0;
          cnt_nxt     = RELOAD;
          busy_nxt    = 1'b1;
          pass_nxt    = 1'b0;
          err_nxt     = '0;
          fail_nxt    = '0;
        end
      end
      WAIT: begin
        if (cnt == 8'd0) state_nxt = SAMPLE;
        else             cnt_nxt   = cnt - 8'd1;
      end
      SAMPLE: begin
        if (mismatch) begin
          fail_nxt[pattern_q] = 1'b1;
          if (err_q != ERR_MAX) err_nxt = err_q + 1'b1;
        end
        // pass must see this pattern's error, so it is taken from err_nxt
        if (pattern_q == 3'd7) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (err_nxt == '0);
        end else begin
          state_nxt   = WAIT;
          pattern_nxt = pattern_q + 3'd1;
          cnt_nxt     = RELOAD;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
